// File: rtl/mem_access_unit.sv
// Handshaked byte/half/word load-store unit over a 32-bit word array, plus a registered debug read port.
// Latency: store response 1 cycle after accept, load response 2 cycles; debug read 1 cycle.
// Backpressure: one request in flight, req_ready low until the response is taken; MEM_MISALIGN_TRAP_EN enables misalignment trapping.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    input  logic [ADDR_W-1:0] debug_addr,
    output logic [31:0]       debug_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [31:0]           debug_rdata_q, debug_rdata_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lo_q, lo_d;
    logic                  uns_q, uns_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [1:0]            req_lo;
    logic                  misalign;
    logic [3:0]            wr_be;
    logic [31:0]           wr_dat;
    logic                  mem_we;
    logic [31:0]           rd_word;
    logic [15:0]           rd_sh;
    logic [31:0]           load_dat;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+2],
                                debug_addr[ADDR_W-1:DEPTH_LOG2+2], debug_addr[1:0]};

    always_comb begin
        req_idx  = req_addr[DEPTH_LOG2+1:2];
        req_lo   = req_addr[1:0];
        misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = req_lo[0];
            default: misalign = |req_lo;
        endcase
`else
        // Without trapping, sub-word offsets are silently aligned down.
        case (req_size)
            2'b00:   ;
            2'b01:   req_lo[0] = 1'b0;
            default: req_lo = 2'b00;
        endcase
`endif
        wr_be  = 4'b0000;
        wr_dat = req_wdata;
        case (req_size)
            2'b00: begin
                wr_be  = 4'b0001 << req_lo;
                wr_dat = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be  = req_lo[1] ? 4'b1100 : 4'b0011;
                wr_dat = {2{req_wdata[15:0]}};
            end
            default: wr_be = 4'b1111;
        endcase
        mem_we = (state_q == IDLE) && req_valid && req_write && !misalign;
    end

    // Stores commit at the accepting edge; the array has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word  = mem[idx_q];
        rd_sh    = 16'(rd_word >> {lo_q, 3'b000});
        load_dat = rd_word;
        case (size_q)
            2'b00:   load_dat = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_dat = {{16{~uns_q & rd_sh[15]}}, rd_sh};
            default: load_dat = rd_word;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_error_d  = resp_error_q;
        resp_rdata_d  = resp_rdata_q;
        size_d        = size_q;
        lo_d          = lo_q;
        uns_d         = uns_q;
        idx_d         = idx_q;
        debug_rdata_d = mem[debug_addr[DEPTH_LOG2+1:2]];
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d       = req_size;
                    lo_d         = req_lo;
                    uns_d        = req_unsigned;
                    idx_d        = req_idx;
                    req_ready_d  = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_error_d = misalign;
                    if (req_write || misalign) begin
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                resp_rdata_d = load_dat;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            debug_rdata_q <= 32'd0;
            size_q        <= 2'b00;
            lo_q          <= 2'b00;
            uns_q         <= 1'b0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_error_q  <= resp_error_d;
            resp_rdata_q  <= resp_rdata_d;
            debug_rdata_q <= debug_rdata_d;
            size_q        <= size_d;
            lo_q          <= lo_d;
            uns_q         <= uns_d;
            idx_q         <= idx_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_error  = resp_error_q;
    assign resp_rdata  = resp_rdata_q;
    assign debug_rdata = debug_rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Handshaked load/store unit with parametrised depth that replaces the combinational data-memory path in the MEM stage. It accepts one byte, halfword or word request at a time, commits stores through per-byte write enables, and returns loads extracted and sign- or zero-extended. A response holds until the pipeline takes it. An independent registered debug read port is kept for the debug unit.

## Interface
- `ADDR_W`, 32: width of request and debug byte addresses.
- `DEPTH_LOG2`, 10: log2 of the number of 32-bit words in the array. Data width is fixed at 32.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `resp_error` out 1: misaligned access (macro-dependent).
- `debug_addr` in ADDR_W: byte address for the debug read.
- `debug_rdata` out 32: registered word at `debug_addr`.

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- Byte lanes are little-endian.
  - Byte uses lane `addr[1:0]`.
  - Half uses lanes {`addr[1]`·2+1, `addr[1]`·2}.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, capture write/size/unsigned/addr/wdata.
    - Store: write the enabled lanes at this edge, then go to RESP.
    - Load: go to ACCESS.
  - ACCESS: `req_ready`=0. Read the array word into the response register, applying extraction and extension. Go to RESP.
  - RESP: `resp_valid`=1 and outputs stable. When `resp_ready`=1, go to IDLE.
- Store writes only its enabled lanes. A byte store writes `wdata[7:0]`; a half store writes `wdata[15:0]`. Other bytes are untouched.
- Load extension:
  - Byte: bit 7 extended unless `req_unsigned`.
  - Half: bit 15 extended unless `req_unsigned`.
  - Word: passed through.
- A load accepted after a store always sees the stored data. The array is single-writer, and the store commits before the load's ACCESS cycle.
- The debug port is independent of the FSM and reads every cycle: `debug_rdata` <= word at `debug_addr[DEPTH_LOG2+1:2]`. When a store writes the same word on the same edge, the debug port returns the old data.
- The array is not reset; its contents persist across `reset`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `debug_rdata`=0.
- Store: accepted at edge E. `resp_valid`=1 from E+1.
- Load: accepted at edge E. `resp_valid`=1 from E+2.
- `resp_valid` and data are held until the `resp_valid&resp_ready` edge. `req_ready` rises in the cycle after that edge.
- Minimum spacing between accepts: 2 cycles for a store, 3 for a load.
- `req_*` inputs are sampled only at the accepting edge. `req_valid` outside IDLE is ignored; no request is lost while `req_ready`=0 if the source holds it.
- `resp_ready` outside RESP is ignored.
- `reset` asserted mid-operation immediately returns to IDLE and drops any pending response. A store already committed stays committed.
- Debug read latency is 1 cycle.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misalignment is half with `addr[0]`=1, or word/reserved with `addr[1:0]`≠0.
  - A misaligned request goes directly to RESP (store timing) with `resp_error`=1 and `resp_rdata`=0. Nothing is written.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced aligned: half clears `addr[0]`, word clears `addr[1:0]`.
  - The access proceeds normally and `resp_error` is always 0.

## Test plan
- Reset then idle → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `debug_rdata`=0.
- Store word 0xDEADBEEF @0x10, then byte store 0x5A @0x12, then word load @0x10 → `resp_rdata`=0xDE5ABEEF. The load's `resp_valid` asserts exactly 2 cycles after accept.
- Word @0x20 = 0x0000F080:
  - signed byte load @0x20 → 0xFFFFFF80;
  - unsigned byte load @0x20 → 0x00000080;
  - signed half load @0x20 → 0xFFFFF080.
- Hold `resp_ready`=0 for 5 cycles after a load → `resp_valid` and `resp_rdata` stay stable, `req_ready`=0, and a `req_valid` pulse in that window is not accepted.
- Word load @0x1002 with DEPTH_LOG2=10:
  - with macro → `resp_error`=1, `resp_rdata`=0, no RAM change;
  - without macro → returns the word at 0x1000, which aliases index 0 (the word at 0x0000).
- Assert `reset` in ACCESS of a load that follows a completed store to 0x40 → next cycle `resp_valid`=0, `req_ready`=1. `debug_addr`=0x40 returns the stored word one cycle later.
